// File: rtl/ym3438_seq_pkg.sv
// -----------------------------------------------------------------------------
// ym3438_seq_pkg
//
// Shared constants, widths and types for the YM3438 slot sequencer.
// The 24-slot rotation is 6 channels by 4 operators. The slot index maps to
// channel = slot % 6 and operator = slot / 6. Operator 0 of channel N
// therefore sits in slot N.
//
// Contents:
//   NSLOTS, NCH, NOPS      rotation geometry
//   SLOT_W, CH_W, OP_W     field widths
//   buf_state_e            register-write buffer state (EMPTY / FULL)
//   slot_ch / slot_op      slot decode helpers
//   slot_next              wrapping slot increment
// -----------------------------------------------------------------------------
package ym3438_seq_pkg;

    localparam int NSLOTS = 24;
    localparam int NCH    = 6;
    localparam int NOPS   = 4;

    localparam int SLOT_W = 5;
    localparam int CH_W   = 3;
    localparam int OP_W   = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    // Channel index of a slot (0..5).
    function automatic logic [CH_W-1:0] slot_ch(input logic [SLOT_W-1:0] s);
        return CH_W'(s % SLOT_W'(NCH));
    endfunction

    // Operator index of a slot (0..3).
    function automatic logic [OP_W-1:0] slot_op(input logic [SLOT_W-1:0] s);
        return OP_W'(s / SLOT_W'(NCH));
    endfunction

    // Next slot in the rotation, wrapping 23 -> 0.
    function automatic logic [SLOT_W-1:0] slot_next(input logic [SLOT_W-1:0] s);
        return (s == SLOT_W'(NSLOTS - 1)) ? '0 : s + 1'b1;
    endfunction

endpackage

// File: rtl/ym3438_clk_phase.sv
// -----------------------------------------------------------------------------
// ym3438_clk_phase
//
// Divides MCLK into the two non-overlapping phase enables of the YM3438 core.
// A counter dcnt runs 0..DIV-1. c1 and c2 are registered decodes of the
// counter, so both are glitch-free single-MCLK pulses:
//   c1 is high in the cycle where dcnt == 0 (never in the first period after reset)
//   c2 is high in the cycle where dcnt == DIV/2
//
// Parameters:
//   DIV    MCLK cycles per phase period; even and >= 4
// Ports:
//   MCLK   in   sole clock, all state on posedge
//   reset  in   synchronous, active-high
//   c1     out  phase-1 enable, one MCLK cycle per DIV
//   c2     out  phase-2 enable, one MCLK cycle per DIV, DIV/2 after c1
// -----------------------------------------------------------------------------
module ym3438_clk_phase #(
    parameter int DIV = 6
) (
    input  logic MCLK,
    input  logic reset,
    output logic c1,
    output logic c2
);

    localparam int CNT_W = $clog2(DIV);

    // An odd or tiny divisor would make c1 and c2 collide or lose symmetry.
    generate
        if (DIV < 4 || (DIV % 2) != 0) begin : g_bad_div
            $error("ym3438_clk_phase: DIV must be even and >= 4");
        end
    endgenerate

    logic [CNT_W-1:0] dcnt;

    // The pulses are decoded one count early because they are registered.
    // They line up with dcnt == 0 and dcnt == DIV/2 on the following cycle.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            dcnt <= '0;
            c1   <= 1'b0;
            c2   <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // right-hand side sees the pre-edge value; blocking here would make
            // c1/c2 decode the already-incremented counter.
            dcnt <= (dcnt == CNT_W'(DIV - 1)) ? '0 : dcnt + 1'b1;
            c1   <= (dcnt == CNT_W'(DIV - 1));
            c2   <= (dcnt == CNT_W'(DIV / 2 - 1));
        end
    end

endmodule

// File: rtl/ym3438_slot_sequencer.sv
// -----------------------------------------------------------------------------
// ym3438_slot_sequencer
//
// Master sequencer of the YM3438 core. It does three things:
//   - generates the c1/c2 phase enables (ym3438_clk_phase);
//   - runs the 24-slot operator/channel rotation, advancing once per c1;
//   - holds a single-entry register-write buffer that releases its write
//     exactly in the operator-0 slot of the target channel, so datapath
//     register files are updated in phase with the rotation.
//
// Parameters:
//   DIV          MCLK cycles per c1/c2 period (even, >= 4)
// Ports:
//   MCLK         in   sole clock
//   reset        in   synchronous, active-high
//   c1, c2       out  phase enables
//   slot         out  current slot 0..23
//   ch, op       out  slot % 6 and slot / 6
//   cycle_start  out  high while slot == 0
//   wr_req       in   write request (level, sampled every MCLK edge)
//   wr_ch        in   target channel, valid 0..5
//   wr_data      in   write payload
//   wr_busy      out  buffer occupied; requests ignored while high
//   wr_err       out  one-cycle pulse when a request with wr_ch 6/7 is rejected
//   upd_en       out  one-cycle write strobe to the datapath
//   upd_data     out  buffered payload, valid with upd_en
// -----------------------------------------------------------------------------
module ym3438_slot_sequencer
    import ym3438_seq_pkg::*;
#(
    parameter int DIV = 6
) (
    input  logic              MCLK,
    input  logic              reset,
    output logic              c1,
    output logic              c2,
    output logic [SLOT_W-1:0] slot,
    output logic [CH_W-1:0]   ch,
    output logic [OP_W-1:0]   op,
    output logic              cycle_start,
    input  logic              wr_req,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [7:0]        wr_data,
    output logic              wr_busy,
    output logic              wr_err,
    output logic              upd_en,
    output logic [7:0]        upd_data
);

    // -------------------------------------------------------------------------
    // Phase generation
    // -------------------------------------------------------------------------
    ym3438_clk_phase #(
        .DIV (DIV)
    ) u_clk_phase (
        .MCLK  (MCLK),
        .reset (reset),
        .c1    (c1),
        .c2    (c2)
    );

    // -------------------------------------------------------------------------
    // Slot rotation
    // -------------------------------------------------------------------------
    always_ff @(posedge MCLK) begin
        if (reset) begin
            slot <= '0;
        end else if (c1) begin
            slot <= slot_next(slot);
        end
    end

    assign ch          = slot_ch(slot);
    assign op          = slot_op(slot);
    assign cycle_start = (slot == '0);

    // -------------------------------------------------------------------------
    // Register-write buffer
    // -------------------------------------------------------------------------
    buf_state_e      buf_state;
    logic [CH_W-1:0] buf_ch;
    logic [7:0]      buf_data;
    logic            busy;

    assign busy    = (buf_state == FULL);
    assign wr_busy = busy;

    // Operator 0 of channel N sits in slot N. Comparing the slot against the
    // channel number directly therefore places the strobe in that slot. The
    // strobe is qualified by c1 so it lasts a single MCLK cycle per visit.
    assign upd_en   = busy & c1 & (slot == SLOT_W'(buf_ch));
    assign upd_data = buf_data;

    always_ff @(posedge MCLK) begin
        if (reset) begin
            // NOTE: the buffered channel and data are cleared on reset. This
            // keeps upd_data at 0 afterwards and discards any pending write.
            buf_state <= EMPTY;
            buf_ch    <= '0;
            buf_data  <= '0;
            wr_err    <= 1'b0;
        end else begin
            wr_err <= 1'b0;
            case (buf_state)
                EMPTY: begin
                    if (wr_req) begin
                        if (wr_ch <= CH_W'(NCH - 1)) begin
                            buf_ch    <= wr_ch;
                            buf_data  <= wr_data;
                            buf_state <= FULL;
                        end else begin
                            wr_err <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    // Requests are ignored while full, including on the release
                    // edge. A held request is taken on the following edge.
                    if (upd_en) begin
                        buf_state <= EMPTY;
                    end
                end
                default: buf_state <= EMPTY;
            endcase
        end
    end

    // The two phase enables must never overlap.
    a_phase_exclusive: assert property (@(posedge MCLK) !(c1 && c2));

endmodule

// File: tb/tb_ym3438_slot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ym3438_slot_sequencer
//
// Bench for ym3438_slot_sequencer with DIV = 6.
//
// Reference timing is computed from n, the number of non-reset MCLK edges since
// reset was released:
//   c2 after edge n  iff  n >= 3 and (n - 3) % 6 == 0
//   c1 after edge n  iff  n >= 6 and n % 6 == 0
//   slot after edge n = (n - 1) / 6 mod 24, for n >= 1
//
// Writes that are expected to be accepted are pushed to a scoreboard queue.
// A negedge monitor pops the queue on every upd_en and compares the payload,
// the slot and c1 against the pushed entry. An upd_en with an empty queue is a
// failure.
// -----------------------------------------------------------------------------
module tb_ym3438_slot_sequencer;

    logic       MCLK = 1'b0;
    logic       reset = 1'b1;
    logic       wr_req = 1'b0;
    logic [2:0] wr_ch = 3'd0;
    logic [7:0] wr_data = 8'h00;

    logic       c1, c2, cycle_start, wr_busy, wr_err, upd_en;
    logic [4:0] slot;
    logic [2:0] ch;
    logic [1:0] op;
    logic [7:0] upd_data;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int n = 0;

    typedef struct packed {
        logic [2:0] ch;
        logic [7:0] data;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;

    always #5 MCLK = ~MCLK;

    ym3438_slot_sequencer #(.DIV(6)) dut (
        .MCLK        (MCLK),
        .reset       (reset),
        .c1          (c1),
        .c2          (c2),
        .slot        (slot),
        .ch          (ch),
        .op          (op),
        .cycle_start (cycle_start),
        .wr_req      (wr_req),
        .wr_ch       (wr_ch),
        .wr_data     (wr_data),
        .wr_busy     (wr_busy),
        .wr_err      (wr_err),
        .upd_en      (upd_en),
        .upd_data    (upd_data)
    );

    // Edge counter for the reference timing.
    always @(posedge MCLK) begin
        if (reset) n = 0;
        else       n = n + 1;
    end

    function automatic logic exp_c1(input int k);
        return (k >= 6) && (k % 6 == 0);
    endfunction

    function automatic logic exp_c2(input int k);
        return (k >= 3) && ((k - 3) % 6 == 0);
    endfunction

    function automatic int exp_slot(input int k);
        return (k == 0) ? 0 : ((k - 1) / 6) % 24;
    endfunction

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    // Scoreboard monitor: every upd_en must match the oldest pending write.
    always @(negedge MCLK) begin
        if (upd_en === 1'b1) begin
            total_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL upd_unexpected: upd_en at slot=%0d upd_data=%h, required no strobe", slot, upd_data);
            end else begin
                mon_e = sb.pop_front();
                if (upd_data !== mon_e.data || slot !== {2'b00, mon_e.ch} || c1 !== 1'b1)
                    $display("FAIL upd_match: got slot=%0d data=%h c1=%b, required slot=%0d data=%h c1=1",
                             slot, upd_data, c1, mon_e.ch, mon_e.data);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic wait_slot(input int s);
        for (int i = 0; i < 200 && exp_slot(n) != s; i++) tick();
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        total_cnt++;
        if (sb.size() != 0) $display("FAIL %s_timeout: %0d writes still pending, required 0", tag, sb.size());
        else                pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wr_req = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if ({c1, c2, slot, ch, op, cycle_start, wr_busy, wr_err, upd_en, upd_data} !==
            {1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00})
            $display("FAIL reset_values: c1=%b c2=%b slot=%0d ch=%0d op=%0d cs=%b busy=%b err=%b upd=%b data=%h, required 0 0 0 0 0 1 0 0 0 00",
                     c1, c2, slot, ch, op, cycle_start, wr_busy, wr_err, upd_en, upd_data);
        else
            pass_cnt++;
    endtask

    task automatic test_phase();
        reset = 1'b0;
        for (int i = 0; i < 36; i++) begin
            tick();
            total_cnt++;
            if (c1 !== exp_c1(n) || c2 !== exp_c2(n))
                $display("FAIL phase: edge %0d got c1=%b c2=%b, required c1=%b c2=%b", n, c1, c2, exp_c1(n), exp_c2(n));
            else
                pass_cnt++;
        end
    endtask

    task automatic test_slot_rotation();
        for (int i = 0; i < 200 && n < 79; i++) tick();
        total_cnt++;
        if (slot !== 5'd13 || ch !== 3'd1 || op !== 2'd2 || cycle_start !== 1'b0)
            $display("FAIL slot13: got slot=%0d ch=%0d op=%0d cs=%b, required 13 1 2 0", slot, ch, op, cycle_start);
        else
            pass_cnt++;
        for (int i = 0; i < 200 && n < 145; i++) begin
            tick();
            total_cnt++;
            if (slot !== 5'(exp_slot(n)) || ch !== 3'(exp_slot(n) % 6) || op !== 2'(exp_slot(n) / 6))
                $display("FAIL slot_decode: edge %0d got slot=%0d ch=%0d op=%0d, required %0d %0d %0d",
                         n, slot, ch, op, exp_slot(n), exp_slot(n) % 6, exp_slot(n) / 6);
            else
                pass_cnt++;
        end
        total_cnt++;
        if (slot !== 5'd0 || cycle_start !== 1'b1)
            $display("FAIL slot_wrap: got slot=%0d cs=%b, required 0 1", slot, cycle_start);
        else
            pass_cnt++;
    endtask

    task automatic test_basic_write();
        wait_slot(5);
        wr_req = 1'b1; wr_ch = 3'd2; wr_data = 8'hA5;
        sb.push_back('{ch: 3'd2, data: 8'hA5});
        tick();
        wr_req = 1'b0;
        total_cnt++;
        if (wr_busy !== 1'b1 || upd_data !== 8'hA5)
            $display("FAIL basic_accept: got busy=%b data=%h, required 1 a5", wr_busy, upd_data);
        else
            pass_cnt++;
        wait_drain("basic_release");
        total_cnt++;
        if (wr_busy !== 1'b0 || upd_en !== 1'b0)
            $display("FAIL basic_after: got busy=%b upd_en=%b, required 0 0", wr_busy, upd_en);
        else
            pass_cnt++;
    endtask

    task automatic test_invalid_channel();
        for (int k = 6; k <= 7; k++) begin
            wr_req = 1'b1; wr_ch = 3'(k); wr_data = 8'h77;
            tick();
            wr_req = 1'b0;
            total_cnt++;
            if (wr_err !== 1'b1 || wr_busy !== 1'b0)
                $display("FAIL invalid_err ch%0d: got err=%b busy=%b, required 1 0", k, wr_err, wr_busy);
            else
                pass_cnt++;
            tick();
            total_cnt++;
            if (wr_err !== 1'b0 || wr_busy !== 1'b0)
                $display("FAIL invalid_pulse ch%0d: got err=%b busy=%b, required 0 0", k, wr_err, wr_busy);
            else
                pass_cnt++;
        end
        repeat (30) tick();
    endtask

    task automatic test_held_request();
        bit found = 1'b0;
        wait_slot(23);
        wr_req = 1'b1; wr_ch = 3'd0; wr_data = 8'h3C;
        sb.push_back('{ch: 3'd0, data: 8'h3C});
        tick();
        wr_ch = 3'd4; wr_data = 8'h5A;   // held request while the buffer is full
        for (int i = 0; i < 200; i++) begin
            if (upd_en === 1'b1) begin
                found = 1'b1;
                break;
            end
            total_cnt++;
            if (wr_busy !== 1'b1 || wr_err !== 1'b0)
                $display("FAIL held_ignore: got busy=%b err=%b, required 1 0", wr_busy, wr_err);
            else
                pass_cnt++;
            tick();
        end
        total_cnt++;
        if (!found) $display("FAIL held_release: got no ch0 strobe, required one");
        else        pass_cnt++;
        tick();
        total_cnt++;
        if (wr_busy !== 1'b0 || wr_err !== 1'b0)
            $display("FAIL held_no_same_edge: got busy=%b err=%b, required 0 0", wr_busy, wr_err);
        else
            pass_cnt++;
        sb.push_back('{ch: 3'd4, data: 8'h5A});
        tick();
        wr_req = 1'b0;
        total_cnt++;
        if (wr_busy !== 1'b1 || upd_data !== 8'h5A)
            $display("FAIL held_accept: got busy=%b data=%h, required 1 5a", wr_busy, upd_data);
        else
            pass_cnt++;
        wait_drain("held_release");
    endtask

    task automatic test_reset_full();
        wait_slot(4);
        wr_req = 1'b1; wr_ch = 3'd3; wr_data = 8'hC3;   // will be discarded, not scoreboarded
        tick();
        wr_req = 1'b0;
        repeat (10) tick();
        total_cnt++;
        if (wr_busy !== 1'b1)
            $display("FAIL rf_full: got busy=%b, required 1", wr_busy);
        else
            pass_cnt++;
        test_reset();
        reset = 1'b0;
        repeat (24 * 6 + 12) tick();
        total_cnt++;
        if (wr_busy !== 1'b0 || upd_data !== 8'h00)
            $display("FAIL rf_discarded: got busy=%b data=%h, required 0 00", wr_busy, upd_data);
        else
            pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_phase();
        test_slot_rotation();
        test_basic_write();
        test_invalid_channel();
        test_held_request();
        test_reset_full();
        total_cnt++;
        if (sb.size() != 0) $display("FAIL scoreboard_end: %0d writes pending, required 0", sb.size());
        else                pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ym3438_slot_sequencer.md
# ym3438_slot_sequencer

Master sequencer for the YM3438 core. It divides MCLK into the two-phase enables `c1`/`c2` that clock every shift-register, counter and latch primitive. It runs the 24-slot operator/channel cycle. It also holds a single-entry register-write buffer that releases a pending write exactly in the target channel's slot, so datapath register files are updated in phase with the slot rotation.

## Interface
Parameters:
- `DIV`, default 6: MCLK cycles per c1/c2 period. Must be even and ≥4; elaborate-time error otherwise.

Ports:
- `MCLK` in 1: sole clock, all state on posedge.
- `reset` in 1: synchronous, active-high.
- `c1` out 1: phase-1 enable, one MCLK cycle per `DIV`.
- `c2` out 1: phase-2 enable, one MCLK cycle per `DIV`, offset `DIV/2` from `c1`.
- `slot` out 5: current slot, 0..23.
- `ch` out 3: `slot % 6`, 0..5.
- `op` out 2: `slot / 6`, 0..3.
- `cycle_start` out 1: high while `slot == 0`.
- `wr_req` in 1: write request, level; sampled every MCLK edge.
- `wr_ch` in 3: target channel; valid values 0..5.
- `wr_data` in 8: write payload.
- `wr_busy` out 1: buffer occupied; requests are ignored while high.
- `wr_err` out 1: one-cycle pulse when a request with `wr_ch` of 6 or 7 is rejected.
- `upd_en` out 1: one-cycle write strobe to the datapath.
- `upd_data` out 8: buffered payload; valid when `upd_en` is high.

## Operation
- **Divider.** `dcnt` counts 0..`DIV`-1 and wraps; reset value 0.
  - Registered: `c1 <= (dcnt == DIV-1)`, `c2 <= (dcnt == DIV/2-1)`.
  - So `c1` is high iff `dcnt == 0` (except directly after reset), and `c2` is high iff `dcnt == DIV/2`.
  - `c1` and `c2` are never high together.
- **Slot counter.** Advances on MCLK edges where `c1 == 1`: 23 → 0, otherwise +1. Reset value 0.
  - `ch`, `op` and `cycle_start` are combinational decodes of registered `slot`.
- **Write buffer.** States are EMPTY and FULL; `wr_busy` equals (state == FULL).
  - **Accept (EMPTY).** On an edge with `wr_req == 1` and `wr_ch ≤ 5`: capture `wr_ch` and `wr_data`, go to FULL.
  - **Reject (EMPTY).** On an edge with `wr_req == 1` and `wr_ch ≥ 6`: `wr_err <= 1` for one cycle, stay EMPTY.
  - **Ignore (FULL).** `wr_req` is ignored entirely; no `wr_err`.
  - **Release (FULL).** `upd_en = busy & c1 & (slot == buf_ch)`. This is combinational and lands in op-0 slot of the target channel. Go to EMPTY on that edge.
  - **No same-edge accept.** A request held during the release cycle is accepted on the following edge.
  - `upd_data` drives the buffered data continuously. It is 0 after reset.
- **Reset.**
  - Clears `dcnt`, `slot`, the buffer state and data, `c1`, `c2` and `wr_err`.
  - A pending write is discarded; no `upd_en` is issued for it.
  - Reset dominates any simultaneous request or release.

## Timing
- Reset values: `c1=0`, `c2=0`, `slot=0`, `ch=0`, `op=0`, `cycle_start=1`, `wr_busy=0`, `wr_err=0`, `upd_en=0`, `upd_data=0`.
- After reset release (edge 1 is the first non-reset edge):
  - First `c2` appears after edge `DIV/2`.
  - First `c1` appears after edge `DIV`.
- Full slot cycle is 24·`DIV` MCLK cycles.
- Accept takes effect at the request edge: `wr_busy` is high the next cycle.
- Release latency is 1 to 24 `c1` periods after accept. A match in the accept cycle itself cannot fire, because `busy` was still 0.
- `wr_err` is registered and lasts exactly one cycle.

## Structure
- **Package `ym3438_seq_pkg`:**
  - Constants: `NSLOTS=24`, `NCH=6`, `NOPS=4`.
  - Widths: `SLOT_W=5`, `CH_W=3`, `OP_W=2`.
  - Buffer-state enum: EMPTY, FULL.
- **Sub-module `ym3438_clk_phase`:** divider plus registered `c1`/`c2` generation, parameterised by `DIV`. The sequencer instantiates it once.

## Test plan
All scenarios use `DIV=6`.
1. **Phase generation.** Deassert reset → `c2` high in cycle 3, `c1` high in cycle 6, each repeating every 6 cycles; never both high.
2. **Slot rotation.** After 13 `c1` pulses → `slot=13`, `ch=1`, `op=2`. After 24 pulses → `slot=0` and `cycle_start=1`.
3. **Basic write.** With `slot=5`, request `wr_ch=2`, `wr_data=0xA5` → `wr_busy=1`. `upd_en` fires exactly one cycle, when `c1=1` and `slot=2`, with `upd_data=0xA5`. `wr_busy=0` the next cycle.
4. **Invalid channel.** Request `wr_ch=6` → `wr_err` pulses for one cycle, `wr_busy` stays 0, no `upd_en`.
5. **Held second request.** Hold `wr_req` with `wr_ch=4` while FULL for `ch=0` → ignored until the ch0 release. Accepted on the next edge; released at `slot=4`.
6. **Reset while FULL.** Assert reset while FULL → all outputs return to reset values and no `upd_en` appears for the discarded write.
